ysyx_220066_wb_arbiter: RTL
===========================

Name: ysyx_220066_wb_arbiter

Overview:
- Shares the single register-file write port between three writeback sources: the in-order main pipeline (MEM→WB), the multi-cycle multiplier and the divider.
- Each out-of-band unit gets a one-entry holding buffer.
- A fixed-priority arbiter picks one source per cycle and registers the winner onto the RF write port and the commit/difftest outputs.
- Also exports a pending-destination mask for hazard detection.

Parameters:
- XLEN, 64, data and PC width.
- MAX_WAIT, 8, aging threshold in cycles; used only with WB_AGING_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- pipe_valid  in  1  main pipeline has a retiring instruction this cycle
- pipe_wen  in  1  main instruction writes rd
- pipe_rd  in  5  destination register
- pipe_data  in  XLEN  result; already selected between ALU and load data upstream
- pipe_nxtpc  in  XLEN  next PC of the retiring instruction
- pipe_error  in  1  instruction faulted; suppress the write
- mul_valid  in  1  multiplier result available
- mul_ready  out  1  multiplier buffer empty
- mul_rd, mul_data, mul_nxtpc, mul_error  in  5/XLEN/XLEN/1  same meaning as the pipe_* fields; the write enable is implied as 1
- div_valid, div_ready, div_rd, div_data, div_nxtpc, div_error  same as mul_*, for the divider
- rf_wen  out  1  register-file write enable (registered)
- rf_rd  out  5  write address (registered)
- rf_data  out  XLEN  write data (registered)
- commit_valid  out  1  one instruction retired last cycle
- commit_nxtpc  out  XLEN  its next PC
- commit_error  out  1  its error flag
- commit_src  out  2  00 pipe, 01 mul, 10 div
- pend_mask  out  32  bit r set while a buffered mul/div result targets register r
- pipe_stall  out  1  main pipeline must hold its WB inputs this cycle

Behaviour:
- Reset (synchronous, active high): both buffers invalid, all registered outputs 0, wait counters 0. A reset mid-operation discards buffered results. mul_ready and div_ready read 1 in the cycle after reset.
- Buffer handshake:
  - x_ready = ~xbuf_v, taken from register state only; there is no combinational path from x_valid.
  - x_valid && x_ready at a posedge loads xbuf with {rd, data, nxtpc, error}.
  - A buffer is freed on the posedge at which it is granted. The unit may reload it from the next cycle, so peak throughput is one result every 2 cycles per unit.
- Arbitration (combinational, each cycle), default priority:
  1. pipe_valid → grant pipe;
  2. else div_buf_v → grant div;
  3. else mul_buf_v → grant mul;
  4. else no grant.
- pipe_stall is constant 0 without WB_AGING_EN; a pipe instruction is always granted in its own cycle.
- Output stage, registered, with 1 cycle latency from grant:
  - commit_valid <= grant_any;
  - rf_wen <= grant_any && wen_sel && ~error_sel && rd_sel != 0;
  - rf_rd, rf_data, commit_nxtpc, commit_error, commit_src <= values of the selected source.
  - With no grant, rf_wen and commit_valid go 0; the data fields hold their last value.
- Faulted instructions (error=1) still produce commit_valid=1 with commit_error=1, but rf_wen=0. A write to x0 commits with rf_wen=0.
- pend_mask = (mul_buf_v && mul_rd != 0 ? 1 << mul_rd : 0) | (div_buf_v && div_rd != 0 ? 1 << div_rd : 0). It is combinational from buffer state and drops on the grant posedge.
- Simultaneous events:
  - mul and div may both load in the same cycle.
  - A unit cannot load while its buffer is full.
  - When both buffers are full and pipe is idle, div wins and mul waits.
- The output register never back-pressures; one retirement per cycle maximum.

Optional Feature:
- Macro: WB_AGING_EN.
- With the macro:
  - Each buffer has a wait counter, clog2(MAX_WAIT+1) bits. It is cleared on load, increments each cycle the buffer is valid and not granted, and saturates at MAX_WAIT.
  - A buffer whose counter == MAX_WAIT is "aged" and takes priority over pipe. Aged div beats aged mul.
  - When an aged buffer is granted while pipe_valid=1, pipe_stall=1 in that cycle. The pipe instruction is not granted; the upstream stage holds its inputs and retries next cycle.
  - pipe_stall=0 whenever pipe_valid=0.
- Without the macro: no counters exist, pipe_stall is tied 0, and MAX_WAIT is unused.

Test Plan:
- Reset, then pipe_valid=1, wen=1, rd=5, data=0x1234, nxtpc=0x80000004 → next cycle rf_wen=1, rf_rd=5, rf_data=0x1234, commit_valid=1, commit_src=00.
- mul_valid=1, rd=7, data=0xAA with pipe idle → cycle+1: mul_ready=0, pend_mask=0x80. Cycle+2: rf_wen=1, rf_rd=7, commit_src=01, pend_mask=0, mul_ready=1.
- mul (rd=3) and div (rd=4) loaded in the same cycle, then pipe idle for 2 cycles → div retires first, then mul. pend_mask goes 0x18 → 0x08 → 0.
- pipe_error=1, rd=9 → commit_valid=1, commit_error=1, rf_wen=0. div result with rd=0 → commit_valid=1, rf_wen=0, pend_mask stays 0.
- pipe_valid held at 1 with mul buffered (rd=2):
  - Without WB_AGING_EN: mul never retires and pipe_stall stays 0.
  - With WB_AGING_EN and MAX_WAIT=8: on the 9th cycle after the mul load, pipe_stall=1; the following cycle commit_src=01, rf_rd=2.
- rst asserted while both buffers are full → next cycle mul_ready=1, div_ready=1, pend_mask=0, rf_wen=0, commit_valid=0. The discarded results never appear.

Source files
------------

// File: rtl/ysyx_220066_wb_arbiter.sv
// Writeback arbiter: shares the RF write port between the main pipe, the multiplier and the divider.
// Latency: 1 cycle from grant to rf_*/commit_* outputs; mul/div results wait in one-entry buffers.
// Backpressure: x_ready = ~buffer_valid (register state only); pipe_stall is asserted only when WB_AGING_EN is defined.
//
// Ports: clk/rst (sync, active high); pipe_* retiring main-pipe instruction; mul_*/div_* valid-ready
// result channels; rf_* registered write port; commit_* registered retirement record;
// pend_mask registers targeted by buffered mul/div results; pipe_stall tells WB to hold.
// Optional macro WB_AGING_EN: per-buffer wait counters; a buffer that has waited MAX_WAIT
// cycles preempts the main pipe.
module ysyx_220066_wb_arbiter #(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid,
    input  logic            pipe_wen,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic [XLEN-1:0] pipe_nxtpc,
    input  logic            pipe_error,
    input  logic            mul_valid,
    output logic            mul_ready,
    input  logic [4:0]      mul_rd,
    input  logic [XLEN-1:0] mul_data,
    input  logic [XLEN-1:0] mul_nxtpc,
    input  logic            mul_error,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic [4:0]      div_rd,
    input  logic [XLEN-1:0] div_data,
    input  logic [XLEN-1:0] div_nxtpc,
    input  logic            div_error,
    output logic            rf_wen,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_nxtpc,
    output logic            commit_error,
    output logic [1:0]      commit_src,
    output logic [31:0]     pend_mask,
    output logic            pipe_stall
);

    localparam logic [1:0] SRC_PIPE = 2'b00;
    localparam logic [1:0] SRC_MUL  = 2'b01;
    localparam logic [1:0] SRC_DIV  = 2'b10;

    // Holding buffers
    logic            mul_buf_v_q, mul_buf_v_d;
    logic [4:0]      mul_buf_rd_q, mul_buf_rd_d;
    logic [XLEN-1:0] mul_buf_data_q, mul_buf_data_d;
    logic [XLEN-1:0] mul_buf_nxtpc_q, mul_buf_nxtpc_d;
    logic            mul_buf_err_q, mul_buf_err_d;

    logic            div_buf_v_q, div_buf_v_d;
    logic [4:0]      div_buf_rd_q, div_buf_rd_d;
    logic [XLEN-1:0] div_buf_data_q, div_buf_data_d;
    logic [XLEN-1:0] div_buf_nxtpc_q, div_buf_nxtpc_d;
    logic            div_buf_err_q, div_buf_err_d;

    // Output stage
    logic            rf_wen_q, rf_wen_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic            commit_valid_q, commit_valid_d;
    logic [XLEN-1:0] commit_nxtpc_q, commit_nxtpc_d;
    logic            commit_error_q, commit_error_d;
    logic [1:0]      commit_src_q, commit_src_d;

    // Arbitration
    logic            gnt_pipe, gnt_mul, gnt_div, gnt_any;
    logic            mul_load, div_load;
    logic            wen_sel, err_sel;
    logic [4:0]      rd_sel;
    logic [XLEN-1:0] data_sel, nxtpc_sel;
    logic [1:0]      src_sel;

`ifdef WB_AGING_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] mul_cnt_q, mul_cnt_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          mul_aged, div_aged;

    assign mul_aged = mul_buf_v_q && (mul_cnt_q == CNT_MAX);
    assign div_aged = div_buf_v_q && (div_cnt_q == CNT_MAX);

    always_comb begin
        gnt_pipe   = 1'b0;
        gnt_mul    = 1'b0;
        gnt_div    = 1'b0;
        pipe_stall = 1'b0;
        if (div_aged) begin
            gnt_div    = 1'b1;
            pipe_stall = pipe_valid;
        end else if (mul_aged) begin
            gnt_mul    = 1'b1;
            pipe_stall = pipe_valid;
        end else if (pipe_valid) begin
            gnt_pipe = 1'b1;
        end else if (div_buf_v_q) begin
            gnt_div = 1'b1;
        end else if (mul_buf_v_q) begin
            gnt_mul = 1'b1;
        end
    end

    // Counters restart on load and stop at MAX_WAIT so "aged" is sticky until granted.
    always_comb begin
        mul_cnt_d = mul_cnt_q;
        div_cnt_d = div_cnt_q;
        if (mul_load) begin
            mul_cnt_d = '0;
        end else if (mul_buf_v_q && !gnt_mul && mul_cnt_q != CNT_MAX) begin
            mul_cnt_d = mul_cnt_q + 1'b1;
        end
        if (div_load) begin
            div_cnt_d = '0;
        end else if (div_buf_v_q && !gnt_div && div_cnt_q != CNT_MAX) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            mul_cnt_q <= mul_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end
`else
    // Aging threshold has no meaning when aging is compiled out.
    localparam int UNUSED_MAX_WAIT = MAX_WAIT;

    always_comb begin
        gnt_pipe   = 1'b0;
        gnt_mul    = 1'b0;
        gnt_div    = 1'b0;
        pipe_stall = 1'b0;
        if (pipe_valid) begin
            gnt_pipe = 1'b1;
        end else if (div_buf_v_q) begin
            gnt_div = 1'b1;
        end else if (mul_buf_v_q) begin
            gnt_mul = 1'b1;
        end
    end
`endif

    assign gnt_any   = gnt_pipe | gnt_mul | gnt_div;
    assign mul_ready = ~mul_buf_v_q;
    assign div_ready = ~div_buf_v_q;
    assign mul_load  = mul_valid && !mul_buf_v_q;
    assign div_load  = div_valid && !div_buf_v_q;

    // Winner's fields
    always_comb begin
        wen_sel   = pipe_wen;
        rd_sel    = pipe_rd;
        data_sel  = pipe_data;
        nxtpc_sel = pipe_nxtpc;
        err_sel   = pipe_error;
        src_sel   = SRC_PIPE;
        if (gnt_div) begin
            wen_sel   = 1'b1;
            rd_sel    = div_buf_rd_q;
            data_sel  = div_buf_data_q;
            nxtpc_sel = div_buf_nxtpc_q;
            err_sel   = div_buf_err_q;
            src_sel   = SRC_DIV;
        end else if (gnt_mul) begin
            wen_sel   = 1'b1;
            rd_sel    = mul_buf_rd_q;
            data_sel  = mul_buf_data_q;
            nxtpc_sel = mul_buf_nxtpc_q;
            err_sel   = mul_buf_err_q;
            src_sel   = SRC_MUL;
        end
    end

    // Buffer next state. A full buffer never loads, so load and grant are exclusive.
    always_comb begin
        mul_buf_v_d     = mul_buf_v_q;
        mul_buf_rd_d    = mul_buf_rd_q;
        mul_buf_data_d  = mul_buf_data_q;
        mul_buf_nxtpc_d = mul_buf_nxtpc_q;
        mul_buf_err_d   = mul_buf_err_q;
        div_buf_v_d     = div_buf_v_q;
        div_buf_rd_d    = div_buf_rd_q;
        div_buf_data_d  = div_buf_data_q;
        div_buf_nxtpc_d = div_buf_nxtpc_q;
        div_buf_err_d   = div_buf_err_q;
        if (gnt_mul) begin
            mul_buf_v_d = 1'b0;
        end
        if (mul_load) begin
            mul_buf_v_d     = 1'b1;
            mul_buf_rd_d    = mul_rd;
            mul_buf_data_d  = mul_data;
            mul_buf_nxtpc_d = mul_nxtpc;
            mul_buf_err_d   = mul_error;
        end
        if (gnt_div) begin
            div_buf_v_d = 1'b0;
        end
        if (div_load) begin
            div_buf_v_d     = 1'b1;
            div_buf_rd_d    = div_rd;
            div_buf_data_d  = div_data;
            div_buf_nxtpc_d = div_nxtpc;
            div_buf_err_d   = div_error;
        end
    end

    // Output stage next state; data fields hold when nothing retires.
    always_comb begin
        commit_valid_d = gnt_any;
        rf_wen_d       = gnt_any && wen_sel && !err_sel && (rd_sel != 5'd0);
        rf_rd_d        = rf_rd_q;
        rf_data_d      = rf_data_q;
        commit_nxtpc_d = commit_nxtpc_q;
        commit_error_d = commit_error_q;
        commit_src_d   = commit_src_q;
        if (gnt_any) begin
            rf_rd_d        = rd_sel;
            rf_data_d      = data_sel;
            commit_nxtpc_d = nxtpc_sel;
            commit_error_d = err_sel;
            commit_src_d   = src_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_buf_v_q     <= 1'b0;
            mul_buf_rd_q    <= '0;
            mul_buf_data_q  <= '0;
            mul_buf_nxtpc_q <= '0;
            mul_buf_err_q   <= 1'b0;
            div_buf_v_q     <= 1'b0;
            div_buf_rd_q    <= '0;
            div_buf_data_q  <= '0;
            div_buf_nxtpc_q <= '0;
            div_buf_err_q   <= 1'b0;
            rf_wen_q        <= 1'b0;
            rf_rd_q         <= '0;
            rf_data_q       <= '0;
            commit_valid_q  <= 1'b0;
            commit_nxtpc_q  <= '0;
            commit_error_q  <= 1'b0;
            commit_src_q    <= '0;
        end else begin
            mul_buf_v_q     <= mul_buf_v_d;
            mul_buf_rd_q    <= mul_buf_rd_d;
            mul_buf_data_q  <= mul_buf_data_d;
            mul_buf_nxtpc_q <= mul_buf_nxtpc_d;
            mul_buf_err_q   <= mul_buf_err_d;
            div_buf_v_q     <= div_buf_v_d;
            div_buf_rd_q    <= div_buf_rd_d;
            div_buf_data_q  <= div_buf_data_d;
            div_buf_nxtpc_q <= div_buf_nxtpc_d;
            div_buf_err_q   <= div_buf_err_d;
            rf_wen_q        <= rf_wen_d;
            rf_rd_q         <= rf_rd_d;
            rf_data_q       <= rf_data_d;
            commit_valid_q  <= commit_valid_d;
            commit_nxtpc_q  <= commit_nxtpc_d;
            commit_error_q  <= commit_error_d;
            commit_src_q    <= commit_src_d;
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_rd        = rf_rd_q;
    assign rf_data      = rf_data_q;
    assign commit_valid = commit_valid_q;
    assign commit_nxtpc = commit_nxtpc_q;
    assign commit_error = commit_error_q;
    assign commit_src   = commit_src_q;

    // x0 is never a real hazard, so it is masked out.
    assign pend_mask = ((mul_buf_v_q && mul_buf_rd_q != 5'd0) ? (32'd1 << mul_buf_rd_q) : 32'd0)
                     | ((div_buf_v_q && div_buf_rd_q != 5'd0) ? (32'd1 << div_buf_rd_q) : 32'd0);

endmodule
